nor_chain_pulse_ctrl: RTL and testbench
=======================================

NOR_CHAIN_PULSE_CTRL -- requirements
Module: nor_chain_pulse_ctrl

Interface
REQ-001 Parameter CNT_W, default 12, width of the cycle counter and latency results.
REQ-002 Parameter PW_W, default 8, width of the PULSE_W input.
REQ-003 Parameter WINDOW, default 1023, observation and timeout window in cycles; must be at most 2^CNT_W-1.
REQ-004 CLK  in  1  single clock; all logic rising-edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 START  in  1  single-cycle request to run one pulse measurement.
REQ-007 MODE  in  2  00 drives both inputs, 01 drives IN_A1 only, 10 drives IN_A2 only, 11 behaves as 00.
REQ-008 PULSE_W  in  PW_W  high-pulse width in cycles; 0 behaves as 1.
REQ-009 OUT_Z1, OUT_Z2  in  1 each  asynchronous outputs of the two parallel NOR chains.
REQ-010 IN_A1, IN_A2  out  1 each  registered chain stimulus.
REQ-011 BUSY  out  1  high from START acceptance until DONE.
REQ-012 DONE  out  1  one-cycle pulse when results are valid.
REQ-013 RISE_LAT, FALL_LAT  out  CNT_W each  measured latencies in cycles.
REQ-014 RISE_SEEN, MISMATCH, TIMEOUT  out  1 each  result flags.

Function
REQ-015 OUT_Z1 and OUT_Z2 SHALL each pass through a two-flop synchronizer; all decisions use the synchronized copies (sZ1, sZ2).
REQ-016 The FSM SHALL have states IDLE, ARM, HIGH, LOW_WAIT and FIN.
REQ-017 IDLE: IN_A1=IN_A2=0. START accepted only in IDLE; START in any other state SHALL be ignored.
REQ-018 On acceptance, the block SHALL:
  - latch MODE and PULSE_W;
  - clear RISE_LAT, FALL_LAT and all flags;
  - set BUSY;
  - go to ARM.
REQ-019 ARM: inputs held 0.
  - When sZ1=0 and sZ2=0, go to HIGH on the next cycle.
  - After WINDOW cycles in ARM without that, set TIMEOUT and go to FIN.
REQ-020 HIGH: the selected inputs SHALL be 1 for exactly max(PULSE_W,1) cycles; unselected inputs stay 0; then go to LOW_WAIT with all inputs 0.
REQ-021 Counter CNT SHALL be 0 in the first cycle the stimulus is high and increment each cycle through HIGH and LOW_WAIT, saturating at 2^CNT_W-1.
REQ-022 First cycle with sZ1=1 after HIGH entry: RISE_LAT SHALL take CNT and RISE_SEEN SHALL be set; later rises are ignored.
REQ-023 First cycle with sZ1=0 after RISE_SEEN is set: FALL_LAT SHALL take CNT minus the pulse width (latency from stimulus fall). If the fall is seen while still in HIGH, FALL_LAT SHALL be 0.
REQ-024 LOW_WAIT SHALL end when either:
  - RISE_SEEN and the fall is captured; or
  - WINDOW cycles have passed since stimulus fall.
REQ-025 If LOW_WAIT ends on the window with RISE_SEEN=1 and no fall captured, TIMEOUT SHALL be set; if RISE_SEEN=0 (pulse filtered by the chain), TIMEOUT SHALL stay 0.
REQ-026 MISMATCH SHALL be sticky-set if sZ1 != sZ2 for two consecutive cycles during HIGH or LOW_WAIT.
REQ-027 FIN: DONE SHALL be high for one cycle, BUSY SHALL drop in the same cycle, then go to IDLE.
REQ-028 Results and flags SHALL hold until the next accepted START.

Reset
REQ-029 RST SHALL force, from any state including mid-pulse:
  - state IDLE;
  - IN_A1, IN_A2, BUSY, DONE, RISE_SEEN, MISMATCH and TIMEOUT to 0;
  - RISE_LAT and FALL_LAT to 0;
  - synchronizer flops to 0.
REQ-030 START asserted in the same cycle as RST SHALL be ignored.

Verification
Bench chain model: OUT = IN delayed by D clock cycles, no filtering unless stated.
REQ-031 MODE=00, PULSE_W=10, D=5 -> IN_A1 and IN_A2 high 10 cycles; RISE_LAT=7, FALL_LAT=7, RISE_SEEN=1, all other flags 0, one DONE pulse.
REQ-032 MODE=01, PULSE_W=0 -> IN_A1 high exactly 1 cycle, IN_A2 stays 0.
REQ-033 Model filters pulses shorter than 4 cycles; PULSE_W=2 -> RISE_SEEN=0, TIMEOUT=0, DONE after WINDOW cycles of LOW_WAIT.
REQ-034 OUT_Z1 stuck at 1 before START -> TIMEOUT=1 after WINDOW ARM cycles; no stimulus pulse issued.
REQ-035 OUT_Z2 delayed 3 cycles more than OUT_Z1 -> MISMATCH=1, RISE_LAT still from Z1.
REQ-036 RST asserted mid-HIGH -> next cycle IN_A1=IN_A2=0 and BUSY=0; START during BUSY produces no second run.

Source files
------------

// File: rtl/nor_chain_pulse_ctrl.sv
// Drives a measured-width pulse into two parallel NOR chains and times the
// synchronized response edges. The results are the rise and fall latencies plus status flags.
module nor_chain_pulse_ctrl #(
    parameter int CNT_W  = 12,
    parameter int PW_W   = 8,
    parameter int WINDOW = 1023
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       MODE,
    input  logic [PW_W-1:0]  PULSE_W,
    input  logic             OUT_Z1,
    input  logic             OUT_Z2,
    output logic             IN_A1,
    output logic             IN_A2,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] RISE_LAT,
    output logic [CNT_W-1:0] FALL_LAT,
    output logic             RISE_SEEN,
    output logic             MISMATCH,
    output logic             TIMEOUT
);

    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_HIGH, S_LOW_WAIT, S_FIN
    } state_t;

    localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW - 1);

    state_t           state_q, state_d;
    logic             z1_meta_q, z1_sync_q, z2_meta_q, z2_sync_q;
    logic             sel1_q, sel1_d, sel2_q, sel2_d;
    logic [PW_W-1:0]  pw_q, pw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, win_q, win_d;
    logic [CNT_W-1:0] rise_lat_q, rise_lat_d, fall_lat_q, fall_lat_d;
    logic             rise_seen_q, rise_seen_d, fall_seen_q, fall_seen_d;
    logic             mismatch_q, mismatch_d, timeout_q, timeout_d;
    logic             diff_prev_q, diff_prev_d;
    logic             in_a1_q, in_a1_d, in_a2_q, in_a2_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [CNT_W-1:0] pw_ext, cnt_inc;
    logic             diff, in_meas;

    always_comb begin
        pw_ext      = CNT_W'(pw_q);
        cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        diff        = z1_sync_q ^ z2_sync_q;
        in_meas     = (state_q == S_HIGH) || (state_q == S_LOW_WAIT);

        state_d     = state_q;
        sel1_d      = sel1_q;
        sel2_d      = sel2_q;
        pw_d        = pw_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        rise_lat_d  = rise_lat_q;
        fall_lat_d  = fall_lat_q;
        rise_seen_d = rise_seen_q;
        fall_seen_d = fall_seen_q;
        mismatch_d  = mismatch_q;
        timeout_d   = timeout_q;
        diff_prev_d = in_meas && diff;

        // Edge capture is shared by HIGH and LOW_WAIT; a fall only counts
        // once a rise was recorded in an earlier cycle.
        if (in_meas) begin
            cnt_d = cnt_inc;
            if (diff && diff_prev_q)
                mismatch_d = 1'b1;
            if (rise_seen_q && !fall_seen_q && !z1_sync_q) begin
                fall_seen_d = 1'b1;
                fall_lat_d  = (cnt_q >= pw_ext) ? cnt_q - pw_ext : '0;
            end
            if (!rise_seen_q && z1_sync_q) begin
                rise_seen_d = 1'b1;
                rise_lat_d  = cnt_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    sel1_d      = (MODE != 2'b10);
                    sel2_d      = (MODE != 2'b01);
                    pw_d        = (PULSE_W == '0) ? PW_W'(1) : PULSE_W;
                    rise_lat_d  = '0;
                    fall_lat_d  = '0;
                    rise_seen_d = 1'b0;
                    fall_seen_d = 1'b0;
                    mismatch_d  = 1'b0;
                    timeout_d   = 1'b0;
                    win_d       = '0;
                    state_d     = S_ARM;
                end
            end
            S_ARM: begin
                if (!z1_sync_q && !z2_sync_q) begin
                    cnt_d   = '0;
                    state_d = S_HIGH;
                end else if (win_q == WIN_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = S_FIN;
                end else begin
                    win_d = win_q + CNT_W'(1);
                end
            end
            S_HIGH: begin
                if (cnt_q == pw_ext - CNT_W'(1)) begin
                    win_d   = '0;
                    state_d = S_LOW_WAIT;
                end
            end
            S_LOW_WAIT: begin
                if (fall_seen_d) begin
                    state_d = S_FIN;
                end else if (win_q == WIN_LAST) begin
                    // A filtered pulse (no rise at all) is not a timeout.
                    timeout_d = rise_seen_d;
                    state_d   = S_FIN;
                end else begin
                    win_d = win_q + CNT_W'(1);
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        in_a1_d = (state_d == S_HIGH) && sel1_d;
        in_a2_d = (state_d == S_HIGH) && sel2_d;
        busy_d  = (state_d == S_ARM) || (state_d == S_HIGH) || (state_d == S_LOW_WAIT);
        done_d  = (state_d == S_FIN);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            z1_meta_q   <= 1'b0;
            z1_sync_q   <= 1'b0;
            z2_meta_q   <= 1'b0;
            z2_sync_q   <= 1'b0;
            sel1_q      <= 1'b0;
            sel2_q      <= 1'b0;
            pw_q        <= '0;
            cnt_q       <= '0;
            win_q       <= '0;
            rise_lat_q  <= '0;
            fall_lat_q  <= '0;
            rise_seen_q <= 1'b0;
            fall_seen_q <= 1'b0;
            mismatch_q  <= 1'b0;
            timeout_q   <= 1'b0;
            diff_prev_q <= 1'b0;
            in_a1_q     <= 1'b0;
            in_a2_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            z1_meta_q   <= OUT_Z1;
            z1_sync_q   <= z1_meta_q;
            z2_meta_q   <= OUT_Z2;
            z2_sync_q   <= z2_meta_q;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            pw_q        <= pw_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            rise_lat_q  <= rise_lat_d;
            fall_lat_q  <= fall_lat_d;
            rise_seen_q <= rise_seen_d;
            fall_seen_q <= fall_seen_d;
            mismatch_q  <= mismatch_d;
            timeout_q   <= timeout_d;
            diff_prev_q <= diff_prev_d;
            in_a1_q     <= in_a1_d;
            in_a2_q     <= in_a2_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign IN_A1     = in_a1_q;
    assign IN_A2     = in_a2_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign RISE_LAT  = rise_lat_q;
    assign FALL_LAT  = fall_lat_q;
    assign RISE_SEEN = rise_seen_q;
    assign MISMATCH  = mismatch_q;
    assign TIMEOUT   = timeout_q;

endmodule

// File: tb/tb_nor_chain_pulse_ctrl.sv
// Bench for nor_chain_pulse_ctrl: delay-line chain model, directed and random
// runs checked against a timeline model derived from the chain delays.
module tb_nor_chain_pulse_ctrl;

    localparam int CNT_W  = 12;
    localparam int PW_W   = 8;
    localparam int WINDOW = 40;

    logic             CLK = 1'b0;
    logic             RST, START;
    logic [1:0]       MODE;
    logic [PW_W-1:0]  PULSE_W;
    logic             OUT_Z1, OUT_Z2;
    logic             IN_A1, IN_A2, BUSY, DONE;
    logic [CNT_W-1:0] RISE_LAT, FALL_LAT;
    logic             RISE_SEEN, MISMATCH, TIMEOUT;

    nor_chain_pulse_ctrl #(.CNT_W(CNT_W), .PW_W(PW_W), .WINDOW(WINDOW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MODE(MODE), .PULSE_W(PULSE_W),
        .OUT_Z1(OUT_Z1), .OUT_Z2(OUT_Z2), .IN_A1(IN_A1), .IN_A2(IN_A2),
        .BUSY(BUSY), .DONE(DONE), .RISE_LAT(RISE_LAT), .FALL_LAT(FALL_LAT),
        .RISE_SEEN(RISE_SEEN), .MISMATCH(MISMATCH), .TIMEOUT(TIMEOUT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Chain model: output = input delayed d cycles; optional filter keeps
    // only pulses of 4+ cycles; optional stuck-at-1 on chain 1.
    int cfg_d1 = 5, cfg_d2 = 5;
    bit cfg_filt = 1'b0, cfg_stuck1 = 1'b0;
    logic [31:0] h1 = '0, h2 = '0;

    always @(posedge CLK) begin
        h1 <= {h1[30:0], IN_A1};
        h2 <= {h2[30:0], IN_A2};
    end

    always_comb begin
        if (cfg_stuck1)    OUT_Z1 = 1'b1;
        else if (cfg_filt) OUT_Z1 = h1[cfg_d1-1] & h1[cfg_d1] & h1[cfg_d1+1] & h1[cfg_d1+2];
        else               OUT_Z1 = h1[cfg_d1-1];
        if (cfg_filt)      OUT_Z2 = h2[cfg_d2-1] & h2[cfg_d2] & h2[cfg_d2+1] & h2[cfg_d2+2];
        else               OUT_Z2 = h2[cfg_d2-1];
    end

    int a1_n = 0, a2_n = 0, busy_n = 0, done_n = 0;
    always @(negedge CLK) begin
        if (IN_A1 === 1'b1) a1_n++;
        if (IN_A2 === 1'b1) a2_n++;
        if (BUSY === 1'b1)  busy_n++;
        if (DONE === 1'b1)  done_n++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Synchronized chain output seen at measurement count k.
    function automatic bit zval(int k, int d, bit sel, bit filt, int pe);
        int t;
        t = k - d - 2;
        if (!sel) return 1'b0;
        if (filt) return (t - 3 >= 0) && (t < pe);
        return (t >= 0) && (t < pe);
    endfunction

    task automatic run(input logic [1:0] mode, input int pw, input int d1, input int d2,
                       input bit filt, input bit stuck, input bit extra_start, input string tag);
        int a1_0, a2_0, busy_0, done_0;
        int pe, rise, fall, k, e_busy, e_a1, e_a2, e_rl, e_fl;
        bit s1, s2, z1, z2, diff, pd, e_mism, e_to, got;
        cfg_d1 = d1; cfg_d2 = d2; cfg_filt = filt; cfg_stuck1 = stuck;
        MODE = mode; PULSE_W = pw[PW_W-1:0];
        repeat (30) @(negedge CLK);
        a1_0 = a1_n; a2_0 = a2_n; busy_0 = busy_n; done_0 = done_n;
        START = 1'b1; @(negedge CLK); START = 1'b0;
        if (extra_start) begin
            repeat (3) @(negedge CLK);
            START = 1'b1; @(negedge CLK); START = 1'b0;
        end
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge CLK);
            if (DONE === 1'b1) got = 1'b1;
        end
        chk({tag, " done_seen"}, 32'(got), 32'd1);
        repeat (2) @(negedge CLK);

        pe = (pw == 0) ? 1 : pw;
        s1 = (mode != 2'b10);
        s2 = (mode != 2'b01);
        if (stuck) begin
            e_busy = WINDOW; e_a1 = 0; e_a2 = 0;
            e_rl = 0; e_fl = 0; rise = -1; e_mism = 0; e_to = 1;
        end else begin
            rise = -1; fall = -1; e_mism = 0; pd = 0;
            for (k = 0; k < 10000; k++) begin
                z1 = zval(k, d1, s1, filt, pe);
                z2 = zval(k, d2, s2, filt, pe);
                diff = (z1 != z2);
                if (diff && pd) e_mism = 1;
                pd = diff;
                if (rise >= 0 && fall < 0 && !z1) fall = k;
                if (rise < 0 && z1) rise = k;
                if (k >= pe && (fall >= 0 || k - pe == WINDOW - 1)) break;
            end
            e_busy = k + 2;
            e_a1 = s1 ? pe : 0;
            e_a2 = s2 ? pe : 0;
            e_rl = (rise >= 0) ? rise : 0;
            e_fl = (fall < 0) ? 0 : ((fall >= pe) ? fall - pe : 0);
            e_to = (rise >= 0) && (fall < 0);
        end
        chk({tag, " in_a1_cycles"}, 32'(a1_n - a1_0), 32'(e_a1));
        chk({tag, " in_a2_cycles"}, 32'(a2_n - a2_0), 32'(e_a2));
        chk({tag, " busy_cycles"},  32'(busy_n - busy_0), 32'(e_busy));
        chk({tag, " done_pulses"},  32'(done_n - done_0), 32'd1);
        chk({tag, " rise_seen"},    32'(RISE_SEEN), 32'(rise >= 0));
        chk({tag, " rise_lat"},     32'(RISE_LAT), 32'(e_rl));
        chk({tag, " fall_lat"},     32'(FALL_LAT), 32'(e_fl));
        chk({tag, " mismatch"},     32'(MISMATCH), 32'(e_mism));
        chk({tag, " timeout"},      32'(TIMEOUT), 32'(e_to));
        chk({tag, " busy_after"},   32'(BUSY), 32'd0);
    endtask

    initial begin
        bit got;
        int d;
        RST = 1'b1; START = 1'b0; MODE = 2'b00; PULSE_W = '0;
        repeat (3) @(negedge CLK);
        chk("rst in_a1", 32'(IN_A1), 0);
        chk("rst in_a2", 32'(IN_A2), 0);
        chk("rst busy", 32'(BUSY), 0);
        chk("rst done", 32'(DONE), 0);
        chk("rst lat", 32'({RISE_LAT, FALL_LAT}), 0);
        chk("rst flags", 32'({RISE_SEEN, MISMATCH, TIMEOUT}), 0);
        RST = 1'b0;

        run(2'b00, 10, 5, 5, 0, 0, 0, "basic");
        chk("basic rise7", 32'(RISE_LAT), 32'd7);
        chk("basic fall7", 32'(FALL_LAT), 32'd7);
        run(2'b01, 0, 4, 4, 0, 0, 0, "pw0_a1only");
        run(2'b00, 2, 5, 5, 1, 0, 0, "filtered");
        run(2'b00, 10, 3, 3, 0, 1, 0, "stuck_z1");
        cfg_stuck1 = 1'b0;
        run(2'b00, 10, 4, 7, 0, 0, 0, "z2_late");
        chk("z2_late rise_from_z1", 32'(RISE_LAT), 32'd6);
        run(2'b10, 6, 3, 3, 0, 0, 0, "a2only");
        run(2'b11, 8, 6, 6, 0, 0, 1, "start_during_busy");

        // Reset mid-HIGH, with START held during the reset cycle.
        cfg_d1 = 5; cfg_d2 = 5; cfg_filt = 0; MODE = 2'b00; PULSE_W = 8'd20;
        repeat (30) @(negedge CLK);
        START = 1'b1; @(negedge CLK); START = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge CLK);
            if (IN_A1 === 1'b1) got = 1'b1;
        end
        chk("midrst reached_high", 32'(got), 32'd1);
        repeat (2) @(negedge CLK);
        RST = 1'b1; START = 1'b1;
        @(negedge CLK);
        chk("midrst in_a1", 32'(IN_A1), 0);
        chk("midrst in_a2", 32'(IN_A2), 0);
        chk("midrst busy", 32'(BUSY), 0);
        chk("midrst flags", 32'({RISE_SEEN, MISMATCH, TIMEOUT}), 0);
        RST = 1'b0; START = 1'b0;
        @(negedge CLK);
        chk("rst_start_ignored busy", 32'(BUSY), 0);

        for (int n = 0; n < 12; n++) begin
            d = int'($urandom_range(1, 10));
            run(2'($urandom_range(0, 3)), int'($urandom_range(0, 15)), d,
                d + int'($urandom_range(0, 3)), bit'($urandom_range(0, 3) == 0),
                1'b0, bit'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
